// File: rtl/simple_single_cpu_pkg.sv
// simple_single_cpu_pkg: opcodes, funct codes and control encodings for the single-cycle CPU
package simple_single_cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
`ifdef CPU_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  typedef enum logic [3:0] {ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_SLT = 4'd4} alu_op_e;
  typedef enum logic {DST_RT = 1'b0, DST_RD = 1'b1} reg_dst_e;
  typedef enum logic [1:0] {PC_SEQ = 2'd0, PC_BR = 2'd1, PC_J = 2'd2} pc_sel_e;
endpackage

// File: rtl/simple_single_cpu_alu.sv
// simple_single_cpu_alu: combinational 32-bit ALU with zero flag
module simple_single_cpu_alu
  import simple_single_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y,
  output logic        zero
);
  always_comb begin
    y = op == ALU_SUB ? a - b :
        op == ALU_AND ? a & b :
        op == ALU_OR  ? a | b :
        op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
    zero = y == 32'd0;
  end
endmodule

// File: rtl/simple_single_cpu.sv
// simple_single_cpu: single-cycle MIPS-subset CPU with inline IM and RF; J enabled by CPU_JUMP_EN
module simple_single_cpu_im #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  logic [31:0] Instr_Mem [0:DEPTH-1];
  assign instr = Instr_Mem[addr];
endmodule

module simple_single_cpu_rf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] Reg_File [0:31];
  assign rd1 = ra1 == 5'd0 ? 32'd0 : Reg_File[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'd0 : Reg_File[ra2];
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) Reg_File[i] <= 32'd0;
    end else if (we && wa != 5'd0) begin
      Reg_File[wa] <= wd;
    end
  end
endmodule

module simple_single_cpu
  import simple_single_cpu_pkg::*;
#(
  parameter int          IM_DEPTH = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic clk_i,
  input logic rst_i
);
  localparam int AW = $clog2(IM_DEPTH);
  logic [31:0] pc, instr, rs_v, rt_v, imm, alu_y, pc4, pc_br, pc_j, npc;
  logic        zero, we, use_imm, take;
  logic [4:0]  wa;
  alu_op_e     aop;
  reg_dst_e    dst;
  pc_sel_e     psel;
  simple_single_cpu_im #(.DEPTH(IM_DEPTH)) IM (.addr(pc[AW+1:2]), .instr(instr));
  simple_single_cpu_rf RF (
    .clk_i(clk_i), .rst_i(rst_i), .ra1(instr[25:21]), .ra2(instr[20:16]),
    .wa(wa), .wd(alu_y), .we(we), .rd1(rs_v), .rd2(rt_v)
  );
  simple_single_cpu_alu ALU (.a(rs_v), .b(use_imm ? imm : rt_v), .op(aop), .y(alu_y), .zero(zero));
  always_comb begin
    we = 1'b0;
    dst = DST_RD;
    aop = ALU_ADD;
    use_imm = 1'b0;
    psel = PC_SEQ;
    case (instr[31:26])
      OP_RTYPE: begin
        we = 1'b1;
        case (instr[5:0])
          FN_ADD:  aop = ALU_ADD;
          FN_SUB:  aop = ALU_SUB;
          FN_AND:  aop = ALU_AND;
          FN_OR:   aop = ALU_OR;
          FN_SLT:  aop = ALU_SLT;
          default: we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        we = 1'b1;
        dst = DST_RT;
        use_imm = 1'b1;
      end
      OP_SLTI: begin
        we = 1'b1;
        dst = DST_RT;
        use_imm = 1'b1;
        aop = ALU_SLT;
      end
      OP_BEQ, OP_BNE: begin
        aop = ALU_SUB;
        psel = PC_BR;
      end
`ifdef CPU_JUMP_EN
      OP_J: psel = PC_J;
`endif
      default: ;
    endcase
  end
  // opcode bit 0 distinguishes BNE from BEQ
  always_comb begin
    imm = {{16{instr[15]}}, instr[15:0]};
    wa = dst == DST_RT ? instr[20:16] : instr[15:11];
    take = instr[26] ? !zero : zero;
    pc4 = pc + 32'd4;
    pc_br = pc4 + {imm[29:0], 2'b00};
    pc_j = {pc4[31:28], instr[25:0], 2'b00};
    npc = psel == PC_BR && take ? pc_br : psel == PC_J ? pc_j : pc4;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc <= RESET_PC;
    else pc <= npc;
  end
endmodule

// File: tb/tb_simple_single_cpu.sv
// tb_simple_single_cpu: directed programs with table-driven register checks
module tb_simple_single_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] prog [0:31];

  typedef struct {
    string       name;
    int          r;
    logic [31:0] exp;
  } vec_t;
  vec_t alu_v [8];

  simple_single_cpu dut (.clk_i(clk_i), .rst_i(rst_i));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
  endtask

  task automatic load();
    for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] = prog[i];
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    chk("reset_pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("reset_r%0d", i), dut.RF.Reg_File[i], 32'h0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk_rest(input string name, input logic [31:0] mask);
    for (int i = 0; i < 32; i++)
      if (!mask[i]) chk($sformatf("%s_r%0d", name, i), dut.RF.Reg_File[i], 32'h0);
  endtask

  initial begin
    alu_v = '{'{"addi_pos", 1, 32'd10}, '{"addi_neg", 2, 32'hFFFF_FFFD},
              '{"add", 3, 32'd7}, '{"sub", 4, 32'd13}, '{"and", 5, 32'd2},
              '{"or", 6, 32'd15}, '{"slt", 7, 32'd1}, '{"slti", 8, 32'd0}};

    clear_prog();
    prog[0] = ri(6'h08, 0, 1, 16'd10);
    prog[1] = ri(6'h08, 0, 2, 16'hFFFD);
    prog[2] = rr(6'h20, 1, 2, 3);
    prog[3] = rr(6'h22, 1, 2, 4);
    prog[4] = rr(6'h24, 1, 3, 5);
    prog[5] = rr(6'h25, 1, 3, 6);
    prog[6] = rr(6'h2A, 2, 1, 7);
    prog[7] = ri(6'h0A, 1, 8, 16'd5);
    prog[8] = ri(6'h04, 0, 0, 16'hFFFF);
    load();
    do_reset();
    #1;
    chk("first_fetch_pc", dut.pc, 32'h0);
    run(20);
    for (int k = 0; k < 8; k++) chk(alu_v[k].name, dut.RF.Reg_File[alu_v[k].r], alu_v[k].exp);
    chk("halt_pc", dut.pc, 32'd32);
    run(3);
    chk("halt_pc_hold", dut.pc, 32'd32);
    chk("halt_r3_hold", dut.RF.Reg_File[3], 32'd7);

    clear_prog();
    prog[0] = ri(6'h08, 0, 0, 16'd5);
    prog[1] = rr(6'h20, 0, 0, 9);
    prog[2] = ri(6'h04, 0, 0, 16'hFFFF);
    load();
    do_reset();
    run(10);
    chk("zero_r0", dut.RF.Reg_File[0], 32'h0);
    chk("zero_r9", dut.RF.Reg_File[9], 32'h0);

    clear_prog();
    prog[0] = ri(6'h08, 0, 1, 16'd0);
    prog[1] = ri(6'h08, 0, 2, 16'd5);
    prog[2] = ri(6'h08, 1, 1, 16'd1);
    prog[3] = ri(6'h05, 1, 2, 16'hFFFE);
    prog[4] = ri(6'h04, 0, 0, 16'hFFFF);
    load();
    do_reset();
    run(100);
    chk("loop_r1", dut.RF.Reg_File[1], 32'd5);
    chk("loop_r2", dut.RF.Reg_File[2], 32'd5);
    chk("loop_pc", dut.pc, 32'd16);
    chk_rest("loop", 32'h0000_0006);

    @(negedge clk_i);
    run(5);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("midrst_r%0d", i), dut.RF.Reg_File[i], 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    run(100);
    chk("rerun_r1", dut.RF.Reg_File[1], 32'd5);
    chk("rerun_r2", dut.RF.Reg_File[2], 32'd5);
    chk("rerun_pc", dut.pc, 32'd16);
    chk_rest("rerun", 32'h0000_0006);

    clear_prog();
    prog[0] = ri(6'h08, 0, 1, 16'd1);
    prog[1] = ri(6'h08, 0, 2, 16'd2);
    prog[2] = ri(6'h04, 1, 2, 16'd1);
    prog[3] = ri(6'h08, 0, 3, 16'd7);
    prog[4] = ri(6'h3F, 1, 3, 16'h1234);
    prog[5] = {6'h02, 26'd10};
    prog[6] = ri(6'h08, 0, 4, 16'd4);
    prog[7] = ri(6'h04, 0, 0, 16'hFFFF);
    prog[10] = ri(6'h08, 0, 5, 16'd5);
    prog[11] = ri(6'h04, 0, 0, 16'hFFFF);
    load();
    do_reset();
    run(20);
    chk("nt_r1", dut.RF.Reg_File[1], 32'd1);
    chk("nt_r2", dut.RF.Reg_File[2], 32'd2);
    chk("nt_fallthru_r3", dut.RF.Reg_File[3], 32'd7);
`ifdef CPU_JUMP_EN
    chk("j_r4", dut.RF.Reg_File[4], 32'd0);
    chk("j_r5", dut.RF.Reg_File[5], 32'd5);
    chk("j_pc", dut.pc, 32'd44);
`else
    chk("j_nop_r4", dut.RF.Reg_File[4], 32'd4);
    chk("j_nop_r5", dut.RF.Reg_File[5], 32'd0);
    chk("j_nop_pc", dut.pc, 32'd28);
`endif
    chk_rest("undef", 32'h0000_003E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_single_cpu.md
Name: simple_single_cpu

Overview:
- Single-cycle 32-bit MIPS-subset processor: fetch, decode, register read, ALU, writeback and next-PC all complete in one clock.
- Top-level block of the single-cycle project. Contains its own instruction memory and register file; there is no data memory.
- Benches preload the program image into the instruction memory and read architectural state from the register file through fixed hierarchical instance names.

Parameters:
- IM_DEPTH, 32, instruction memory depth in 32-bit words.
- RESET_PC, 0, PC value after reset (byte address).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.

Behaviour:
- Required instance and array names (benches depend on them):
  - Instruction memory instance IM, containing array Instr_Mem [0:IM_DEPTH-1] of 32 bits.
  - Register file instance RF, containing array Reg_File [0:31] of 32 bits.
- Reset (rst_i=0, asynchronous): PC=RESET_PC and all 32 registers = 0. Instr_Mem is never reset; it keeps its loaded contents. Execution starts on the first rising edge after rst_i returns high.
- PC:
  - Byte address; the fetch index is PC[6:2]. Indexing wraps modulo IM_DEPTH.
  - Default next PC = PC+4, with 32-bit wrap.
- Instruction memory: combinational, read-only.
- Register file:
  - Two combinational read ports, one synchronous write port (rising edge).
  - Writes to $0 are discarded; $0 always reads 0.
  - A read of a register being written in the same cycle returns the old value.
- Instruction set. Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
  - R-type (op=0x00), result to rd:
    - funct 0x20 ADD: rd=rs+rt.
    - funct 0x22 SUB: rd=rs-rt.
    - funct 0x24 AND.
    - funct 0x25 OR.
    - funct 0x2A SLT: signed compare, result 1 or 0.
  - I-type, result to rt:
    - op 0x08 ADDI: rt=rs+sext(imm16).
    - op 0x0A SLTI: rt=(signed rs < sext(imm)) ? 1 : 0.
  - Branches:
    - op 0x04 BEQ: if rs==rt, PC = PC+4 + (sext(imm)<<2).
    - op 0x05 BNE: same target, taken when rs!=rt.
- Arithmetic: 32-bit two's complement, wraps on overflow. No overflow traps and no delay slots.
- Any other opcode or funct executes as a NOP: no register write, PC+4.
- Branch to self (imm=0xFFFF) is a legal halt idiom: PC holds and registers stay stable.
- Reset asserted mid-program: state clears immediately, and the program restarts at RESET_PC after release.

Optional Feature:
- Macro CPU_JUMP_EN.
- Defined: op 0x02 J is supported, with PC = {PC+4[31:28], instr[25:0], 2'b00}.
- Undefined: op 0x02 is a NOP, like any other unsupported opcode.

Decomposition:
- Shared package (simple_single_cpu_pkg) holds:
  - Opcode and funct constants.
  - The 4-bit ALU control enum: ADD, SUB, AND, OR, SLT.
  - Register-destination select and next-PC select encodings.
- One natural sub-module: simple_single_cpu_alu, a combinational ALU producing result and zero flag.
- The register file and instruction memory are simple inline instances named RF and IM.

Test Plan:
- Reset: hold rst_i=0 for half a cycle, then release with any program loaded → PC=0, all Reg_File entries 0, execution starts at word 0.
- ALU program → expected final state:
  - addi $1,$0,10 → $1=10.
  - addi $2,$0,-3 → $2=-3.
  - add $3,$1,$2 → $3=7.
  - sub $4,$1,$2 → $4=13.
  - and $5,$1,$3 → $5=2.
  - or $6,$1,$3 → $6=15.
  - slt $7,$2,$1 → $7=1.
  - slti $8,$1,5 → $8=0.
- $0 protection: addi $0,$0,5, then add $9,$0,$0 → $0=0 and $9=0.
- Loop: addi $1,$0,0; addi $2,$0,5; loop: addi $1,$1,1; bne $1,$2,loop; beq $0,$0,-1 → after 100 cycles $1=5, $2=5, and all other registers 0.
- Branch not-taken and undefined opcode:
  - beq $1,$2 with $1≠$2 falls through.
  - Opcode 0x3F leaves all registers unchanged.
- Mid-run reset: pulse rst_i low during the loop → all registers read 0 immediately; the rerun finishes with the same final values.
